// File: rtl/ssit_update_sched_if.sv
// Request/update bundle between the LSQ violation reporters, the scheduler and the SSIT.
// No logic of its own; the scheduler adds two cycles from request acceptance to update strobe.
// Requesters see per-port rdy (valid/ready); the SSIT side has no backpressure.
interface ssit_update_sched_if #(
  parameter int IDX_W = 12,
  parameter int CNT_W = 3
);
  logic             req0_v_in;
  logic [IDX_W-1:0] req0_ld_idx_in;
  logic [IDX_W-1:0] req0_st_idx_in;
  logic             req0_rdy_out;
  logic             req1_v_in;
  logic [IDX_W-1:0] req1_ld_idx_in;
  logic [IDX_W-1:0] req1_st_idx_in;
  logic             req1_rdy_out;
  logic             update_v_out;
  logic [IDX_W-1:0] update_index1_out;
  logic [IDX_W-1:0] update_index2_out;
  logic [CNT_W-1:0] pending_cnt_out;

  // Requester / observer side (LSQ reporters, SSIT, bench)
  modport master (
    output req0_v_in, req0_ld_idx_in, req0_st_idx_in,
    output req1_v_in, req1_ld_idx_in, req1_st_idx_in,
    input  req0_rdy_out, req1_rdy_out,
    input  update_v_out, update_index1_out, update_index2_out, pending_cnt_out
  );

  // Scheduler side
  modport slave (
    input  req0_v_in, req0_ld_idx_in, req0_st_idx_in,
    input  req1_v_in, req1_ld_idx_in, req1_st_idx_in,
    output req0_rdy_out, req1_rdy_out,
    output update_v_out, update_index1_out, update_index2_out, pending_cnt_out
  );
endinterface

// File: rtl/ssit_update_sched.sv
// Buffers store-set training pairs from two LSQ ports and issues them to the SSIT, one per 2 cycles.
// Latency: accepted at edge ending cycle T into an empty FIFO -> update_v_out in cycle T+2.
// Backpressure: rdy from registered free slots with round-robin tie-break; optional SSIT_UPD_DEDUP_EN acks duplicates.
module ssit_update_sched #(
  parameter int IDX_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic                clock,
  input logic                reset_n,
  ssit_update_sched_if.slave sif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [IDX_W-1:0] ld_mem_q [FIFO_DEPTH];
  logic [IDX_W-1:0] st_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, free;
  logic             rr_q, rr_d;
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] upd_ld_q, upd_ld_d, upd_st_q, upd_st_d;
  logic             base_rdy0, base_rdy1, rdy0, rdy1, push0, push1, pop;

  assign free      = CNT_W'(FIFO_DEPTH) - cnt_q;
  assign pop       = (state_q == ST_ISSUE);
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  // Slot arbitration from registered free count; the rr port wins the last slot
  always_comb begin
    base_rdy0 = 1'b0;
    base_rdy1 = 1'b0;
    if (free >= CNT_W'(2)) begin
      base_rdy0 = 1'b1;
      base_rdy1 = 1'b1;
    end else if (free == CNT_W'(1)) begin
      base_rdy0 = !rr_q || !sif.req1_v_in;
      base_rdy1 = rr_q || !sif.req0_v_in;
    end
  end

`ifdef SSIT_UPD_DEDUP_EN
  logic             match0, match1, same_pair;
  logic [PTR_W-1:0] offs;

  // Compare each incoming pair against all occupied entries, head included
  always_comb begin
    match0 = 1'b0;
    match1 = 1'b0;
    offs   = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(offs) < cnt_q) begin
        if (ld_mem_q[i] == sif.req0_ld_idx_in && st_mem_q[i] == sif.req0_st_idx_in) match0 = 1'b1;
        if (ld_mem_q[i] == sif.req1_ld_idx_in && st_mem_q[i] == sif.req1_st_idx_in) match1 = 1'b1;
      end
    end
  end

  // Duplicates are acked without a slot; a same-cycle identical pair shares one slot
  always_comb begin
    same_pair = sif.req0_v_in && sif.req1_v_in &&
                (sif.req0_ld_idx_in == sif.req1_ld_idx_in) &&
                (sif.req0_st_idx_in == sif.req1_st_idx_in);
    rdy0  = match0 || (same_pair ? (free != '0) : base_rdy0);
    rdy1  = match1 || (same_pair ? (free != '0) : base_rdy1);
    push0 = sif.req0_v_in && rdy0 && !match0;
    push1 = sif.req1_v_in && rdy1 && !match1 && !(same_pair && push0);
  end
`else
  // Every accepted request takes a slot
  always_comb begin
    rdy0  = base_rdy0;
    rdy1  = base_rdy1;
    push0 = sif.req0_v_in && rdy0;
    push1 = sif.req1_v_in && rdy1;
  end
`endif

  // Pointer, occupancy, round-robin and FSM next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    rr_d     = rr_q;
    if (sif.req0_v_in && sif.req1_v_in && (rdy0 != rdy1)) rr_d = rdy0;
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cnt_q != '0) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = (cnt_q != '0) ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    upd_ld_d = upd_ld_q;
    upd_st_d = upd_st_q;
    if (state_d == ST_ISSUE) begin
      upd_ld_d = ld_mem_q[rd_ptr_q];
      upd_st_d = st_mem_q[rd_ptr_q];
    end
  end

  // Entry storage; on a dual push the rr port lands first so it is older
  always_ff @(posedge clock) begin
    if (push0 && push1) begin
      if (rr_q) begin
        ld_mem_q[wr_ptr_q]  <= sif.req1_ld_idx_in;
        st_mem_q[wr_ptr_q]  <= sif.req1_st_idx_in;
        ld_mem_q[wr_ptr_p1] <= sif.req0_ld_idx_in;
        st_mem_q[wr_ptr_p1] <= sif.req0_st_idx_in;
      end else begin
        ld_mem_q[wr_ptr_q]  <= sif.req0_ld_idx_in;
        st_mem_q[wr_ptr_q]  <= sif.req0_st_idx_in;
        ld_mem_q[wr_ptr_p1] <= sif.req1_ld_idx_in;
        st_mem_q[wr_ptr_p1] <= sif.req1_st_idx_in;
      end
    end else if (push0) begin
      ld_mem_q[wr_ptr_q] <= sif.req0_ld_idx_in;
      st_mem_q[wr_ptr_q] <= sif.req0_st_idx_in;
    end else if (push1) begin
      ld_mem_q[wr_ptr_q] <= sif.req1_ld_idx_in;
      st_mem_q[wr_ptr_q] <= sif.req1_st_idx_in;
    end
  end

  // Control state with async reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      state_q  <= ST_IDLE;
      upd_ld_q <= '0;
      upd_st_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      state_q  <= state_d;
      upd_ld_q <= upd_ld_d;
      upd_st_q <= upd_st_d;
    end
  end

  assign sif.req0_rdy_out      = rdy0;
  assign sif.req1_rdy_out      = rdy1;
  assign sif.update_v_out      = (state_q == ST_ISSUE);
  assign sif.update_index1_out = upd_ld_q;
  assign sif.update_index2_out = upd_st_q;
  assign sif.pending_cnt_out   = cnt_q;
endmodule
